cache_mem_arbiter: RTL and testbench
====================================

Name: cache_mem_arbiter

Overview:
- Arbitrates the single physical-memory port between the LC-3b pipeline's instruction cache (fetch stage) and data cache (MEM stage), one whole-line transaction at a time.
- Grants, latches the request, drives physical memory, then returns a registered line and a one-cycle response to the winning cache.
- Uses round-robin between caches so neither the fetch nor the MEM/WB side of the pipeline starves.

Parameters:
- ADDR_WIDTH, 16, byte address width (lc3b_word).
- LINE_WIDTH, 128, cache line width in bits.

Ports:
- clk  in  1  clock; all state on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- i_read  in  1  icache line-read request; held until i_resp.
- i_address  in  ADDR_WIDTH  icache line address.
- i_rdata  out  LINE_WIDTH  line returned to icache.
- i_resp  out  1  one-cycle completion pulse to icache.
- d_read  in  1  dcache line-read request; held until d_resp.
- d_write  in  1  dcache line-writeback request; held until d_resp.
- d_address  in  ADDR_WIDTH  dcache line address.
- d_wdata  in  LINE_WIDTH  dcache writeback line.
- d_rdata  out  LINE_WIDTH  line returned to dcache.
- d_resp  out  1  one-cycle completion pulse to dcache.
- pmem_read  out  1  memory read strobe.
- pmem_write  out  1  memory write strobe.
- pmem_address  out  ADDR_WIDTH  memory address.
- pmem_wdata  out  LINE_WIDTH  memory write line.
- pmem_rdata  in  LINE_WIDTH  memory read line, valid with pmem_resp.
- pmem_resp  in  1  memory completion.

Behaviour:
- Reset (async, reset_n=0): state=IDLE, last_served=I, all outputs 0 (strobes, resps, rdata, address, wdata). Reset mid-transaction abandons it; no resp is issued.
- States: IDLE, SERVE_I, SERVE_D, RELEASE.
- IDLE: if only i_read, go to SERVE_I. If only d_read or d_write, go to SERVE_D. If both caches request, grant the cache not equal to last_served, so the first contest after reset goes to D. On grant, latch address, op (rd/wr), and wdata into internal registers.
- d_read and d_write both high is illegal; write takes precedence.
- SERVE_x: pmem_read/pmem_write asserted (registered) from the first SERVE cycle, i.e. one cycle after the request is seen in IDLE. pmem_address/pmem_wdata come from the latched registers and are stable for the whole transaction, even if cache inputs change.
- On pmem_resp in SERVE_x, the next cycle:
  - x_resp=1 for exactly one cycle.
  - x_rdata = captured pmem_rdata. Writes also capture it; the value is don't-care.
  - pmem strobes drop to 0.
  - last_served=x.
  - state goes to RELEASE.
- x_rdata holds its value until the next response to that cache.
- RELEASE: one idle cycle so the cache can drop its request. No new grant; go to IDLE.
- Latency: request-to-resp = memory latency + 2 cycles. Back-to-back transactions are separated by at least 2 non-strobe cycles (RELEASE, IDLE).
- Requests arriving during SERVE or RELEASE wait. No queue beyond the held request lines.
- pmem_resp outside SERVE is ignored.
- Never more than one of i_resp, d_resp high; never pmem_read and pmem_write both high.

Test Plan:
- Reset: assert reset_n=0 mid-SERVE_D with pmem_write=1 -> all outputs 0 asynchronously; after release, state IDLE, no d_resp emitted.
- Single icache read: i_read=1, i_address=16'h1230; memory returns 128'hA5..A5 after 3 cycles -> pmem_read=1 with pmem_address=16'h1230 from cycle 1; i_resp pulses one cycle after pmem_resp; i_rdata=128'hA5..A5; total 5 cycles.
- Simultaneous after reset: i_read and d_read both asserted at cycle 0 -> D served first (pmem_address=d_address). Then, with i_read still held, I is served next, starting 2 cycles after d_resp.
- Round-robin: both caches request continuously for 4 transactions -> grant order D, I, D, I.
- Dcache writeback: d_write=1, d_address=16'h8040, d_wdata=128'h0123..CDEF; change d_wdata mid-transaction -> pmem_write=1, and pmem_wdata stays at the original value until pmem_resp; d_resp=1 once; i_resp=0 throughout.
- Illegal op / stray resp: d_read=d_write=1 -> write performed. pmem_resp pulsed in IDLE -> no resp outputs and no state change.

Source files
------------

// File: rtl/cache_mem_arbiter.sv
// Round-robin arbiter sharing one physical-memory port between the icache and
// dcache; one whole-line transaction at a time, with registered line and response.
module cache_mem_arbiter #(
  parameter int ADDR_WIDTH = 16,
  parameter int LINE_WIDTH = 128
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  i_read,
  input  logic [ADDR_WIDTH-1:0] i_address,
  output logic [LINE_WIDTH-1:0] i_rdata,
  output logic                  i_resp,
  input  logic                  d_read,
  input  logic                  d_write,
  input  logic [ADDR_WIDTH-1:0] d_address,
  input  logic [LINE_WIDTH-1:0] d_wdata,
  output logic [LINE_WIDTH-1:0] d_rdata,
  output logic                  d_resp,
  output logic                  pmem_read,
  output logic                  pmem_write,
  output logic [ADDR_WIDTH-1:0] pmem_address,
  output logic [LINE_WIDTH-1:0] pmem_wdata,
  input  logic [LINE_WIDTH-1:0] pmem_rdata,
  input  logic                  pmem_resp,
  output logic [1:0]            dbg_state
);

  // Handshake: a cache holds read/write (and its address/wdata) until it sees a
  // one-cycle resp; memory holds its strobe view until a one-cycle pmem_resp.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_I = 2'd1,
    SERVE_D = 2'd2,
    RELEASE = 2'd3
  } state_e;

  state_e                state_q, state_d;
  logic                  last_d_q, last_d_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [LINE_WIDTH-1:0] wdata_q, wdata_d;
  logic                  rd_q, rd_d;
  logic                  wr_q, wr_d;
  logic                  i_resp_q, i_resp_d;
  logic                  d_resp_q, d_resp_d;
  logic [LINE_WIDTH-1:0] i_rdata_q, i_rdata_d;
  logic [LINE_WIDTH-1:0] d_rdata_q, d_rdata_d;
  logic                  d_req;
  logic                  grant_d;

  assign d_req = d_read | d_write;

  always_comb begin
    state_d   = state_q;
    last_d_d  = last_d_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    rd_d      = rd_q;
    wr_d      = wr_q;
    i_resp_d  = 1'b0;
    d_resp_d  = 1'b0;
    i_rdata_d = i_rdata_q;
    d_rdata_d = d_rdata_q;
    // On a contest the cache that was not served last wins.
    grant_d   = d_req && (!i_read || !last_d_q);
    case (state_q)
      IDLE: begin
        if (grant_d) begin
          state_d = SERVE_D;
          addr_d  = d_address;
          wdata_d = d_wdata;
          wr_d    = d_write;
          rd_d    = !d_write;
        end else if (i_read) begin
          state_d = SERVE_I;
          addr_d  = i_address;
          wr_d    = 1'b0;
          rd_d    = 1'b1;
        end
      end
      SERVE_I, SERVE_D: begin
        if (pmem_resp) begin
          state_d = RELEASE;
          rd_d    = 1'b0;
          wr_d    = 1'b0;
          if (state_q == SERVE_I) begin
            i_resp_d  = 1'b1;
            i_rdata_d = pmem_rdata;
            last_d_d  = 1'b0;
          end else begin
            d_resp_d  = 1'b1;
            d_rdata_d = pmem_rdata;
            last_d_d  = 1'b1;
          end
        end
      end
      RELEASE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      last_d_q  <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      rd_q      <= 1'b0;
      wr_q      <= 1'b0;
      i_resp_q  <= 1'b0;
      d_resp_q  <= 1'b0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
    end else begin
      state_q   <= state_d;
      last_d_q  <= last_d_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      rd_q      <= rd_d;
      wr_q      <= wr_d;
      i_resp_q  <= i_resp_d;
      d_resp_q  <= d_resp_d;
      i_rdata_q <= i_rdata_d;
      d_rdata_q <= d_rdata_d;
    end
  end

  assign pmem_read    = rd_q;
  assign pmem_write   = wr_q;
  assign pmem_address = addr_q;
  assign pmem_wdata   = wdata_q;
  assign i_resp       = i_resp_q;
  assign d_resp       = d_resp_q;
  assign i_rdata      = i_rdata_q;
  assign d_rdata      = d_rdata_q;
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Directed bench for cache_mem_arbiter: hand-computed grants, strobes, latched
// address/wdata, response pulses and reset behaviour.
`timescale 1ns/1ps
module tb_cache_mem_arbiter;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         i_read;
  logic [15:0]  i_address;
  logic [127:0] i_rdata;
  logic         i_resp;
  logic         d_read;
  logic         d_write;
  logic [15:0]  d_address;
  logic [127:0] d_wdata;
  logic [127:0] d_rdata;
  logic         d_resp;
  logic         pmem_read;
  logic         pmem_write;
  logic [15:0]  pmem_address;
  logic [127:0] pmem_wdata;
  logic [127:0] pmem_rdata;
  logic         pmem_resp;
  logic [1:0]   dbg_state;

  int total = 0;
  int bad   = 0;
  logic [127:0] exp_i_rdata = '0;
  logic [127:0] exp_d_rdata = '0;

  // clock / reset block
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired obs=running exp=finished");
    $fatal(1, "watchdog");
  end

  cache_mem_arbiter #(.ADDR_WIDTH(16), .LINE_WIDTH(128)) dut (
    .clk(clk), .reset_n(reset_n),
    .i_read(i_read), .i_address(i_address), .i_rdata(i_rdata), .i_resp(i_resp),
    .d_read(d_read), .d_write(d_write), .d_address(d_address), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_resp(d_resp),
    .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_address(pmem_address),
    .pmem_wdata(pmem_wdata), .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp),
    .dbg_state(dbg_state)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  // RELEASE -> IDLE cycle between transactions
  task automatic gap();
    step();
    chk("gap_state", 128'(dbg_state), 128'(0));
    chk("gap_strobes_resps", 128'({pmem_read, pmem_write, i_resp, d_resp}), 128'(0));
  endtask

  // Driver + checker for one granted transaction: request is already driven.
  task automatic txn(input logic [15:0] a, input bit wr, input bit to_d, input int lat,
                     input logic [127:0] wd, input logic [127:0] rd);
    logic [15:0]  sv_ia, sv_da;
    logic [127:0] sv_wd;
    logic [31:0]  r;
    step();
    chk("serve_state", 128'(dbg_state), to_d ? 128'(2) : 128'(1));
    sv_ia = i_address; sv_da = d_address; sv_wd = d_wdata;
    r = $urandom; i_address = r[15:0]; d_address = r[31:16];
    d_wdata = {4{$urandom}};
    for (int k = 0; k < lat; k++) begin
      if (k > 0) step();
      chk("pmem_read", 128'(pmem_read), 128'(!wr));
      chk("pmem_write", 128'(pmem_write), 128'(wr));
      chk("pmem_address", 128'(pmem_address), 128'(a));
      if (wr) chk("pmem_wdata", pmem_wdata, wd);
      chk("resp_during_serve", 128'({i_resp, d_resp}), 128'(0));
    end
    pmem_resp = 1'b1; pmem_rdata = rd;
    step();
    pmem_resp = 1'b0; pmem_rdata = {4{$urandom}};
    i_address = sv_ia; d_address = sv_da; d_wdata = sv_wd;
    if (to_d) exp_d_rdata = rd; else exp_i_rdata = rd;
    chk("i_resp", 128'(i_resp), 128'(!to_d));
    chk("d_resp", 128'(d_resp), 128'(to_d));
    chk("strobes_after_resp", 128'({pmem_read, pmem_write}), 128'(0));
    chk("release_state", 128'(dbg_state), 128'(3));
    chk("i_rdata", i_rdata, exp_i_rdata);
    chk("d_rdata", d_rdata, exp_d_rdata);
  endtask

  initial begin
    logic [127:0] line_a5;
    logic [127:0] wline;
    line_a5 = {16{8'hA5}};
    wline   = 128'h0123456789ABCDEF0123456789ABCDEF;
    reset_n = 1'b0;
    i_read = 1'b0; i_address = '0;
    d_read = 1'b0; d_write = 1'b0; d_address = '0; d_wdata = '0;
    pmem_rdata = '0; pmem_resp = 1'b0;

    // reset values
    step(); step();
    chk("rst_state", 128'(dbg_state), 128'(0));
    chk("rst_ctrl", 128'({pmem_read, pmem_write, i_resp, d_resp}), 128'(0));
    chk("rst_addr", 128'(pmem_address), 128'(0));
    chk("rst_wdata", pmem_wdata, '0);
    chk("rst_rdata", i_rdata | d_rdata, '0);

    // simultaneous requests after reset, held continuously: D, I, D, I
    reset_n = 1'b1;
    i_read = 1'b1; i_address = 16'h1000;
    d_read = 1'b1; d_address = 16'h2000;
    txn(16'h2000, 1'b0, 1'b1, 2, '0, 128'h11111111_22222222_33333333_44444444);
    gap();
    txn(16'h1000, 1'b0, 1'b0, 3, '0, 128'h55555555_66666666_77777777_88888888);
    gap();
    txn(16'h2000, 1'b0, 1'b1, 1, '0, 128'h99999999_AAAAAAAA_BBBBBBBB_CCCCCCCC);
    gap();
    txn(16'h1000, 1'b0, 1'b0, 2, '0, 128'hDDDDDDDD_EEEEEEEE_FFFFFFFF_00000000);
    i_read = 1'b0; d_read = 1'b0;
    gap();

    // single icache read, memory latency 3
    i_read = 1'b1; i_address = 16'h1230;
    txn(16'h1230, 1'b0, 1'b0, 3, '0, line_a5);
    i_read = 1'b0;
    gap();

    // dcache writeback; d_wdata is scrambled mid-transaction inside txn
    d_write = 1'b1; d_address = 16'h8040; d_wdata = wline;
    txn(16'h8040, 1'b1, 1'b1, 4, wline, 128'hDEAD);
    d_write = 1'b0;
    gap();

    // illegal read+write: write wins
    d_read = 1'b1; d_write = 1'b1; d_address = 16'h4444; d_wdata = ~wline;
    txn(16'h4444, 1'b1, 1'b1, 2, ~wline, 128'hBEEF);
    d_read = 1'b0; d_write = 1'b0;
    gap();

    // stray pmem_resp in IDLE
    pmem_resp = 1'b1; pmem_rdata = {4{32'h5A5A5A5A}};
    step();
    pmem_resp = 1'b0;
    chk("stray_state", 128'(dbg_state), 128'(0));
    chk("stray_ctrl", 128'({pmem_read, pmem_write, i_resp, d_resp}), 128'(0));
    chk("stray_rdata_i", i_rdata, exp_i_rdata);
    chk("stray_rdata_d", d_rdata, exp_d_rdata);

    // asynchronous reset in the middle of a SERVE_D write
    d_write = 1'b1; d_address = 16'h9000; d_wdata = wline;
    step();
    chk("pre_rst_write", 128'(pmem_write), 128'(1));
    #2 reset_n = 1'b0;
    #1;
    chk("arst_state", 128'(dbg_state), 128'(0));
    chk("arst_ctrl", 128'({pmem_read, pmem_write, i_resp, d_resp}), 128'(0));
    chk("arst_addr", 128'(pmem_address), 128'(0));
    chk("arst_wdata", pmem_wdata, '0);
    chk("arst_rdata", i_rdata | d_rdata, '0);
    d_write = 1'b0;
    step();
    reset_n = 1'b1;
    step();
    chk("post_rst_state", 128'(dbg_state), 128'(0));
    chk("post_rst_dresp", 128'({d_resp, i_resp}), 128'(0));
    step();
    chk("post_rst_dresp2", 128'({d_resp, i_resp}), 128'(0));

    // last_served restored to I: first contest after reset goes to D
    i_read = 1'b1; i_address = 16'h1111;
    d_read = 1'b1; d_address = 16'h2222;
    step();
    chk("contest_state", 128'(dbg_state), 128'(2));
    chk("contest_addr", 128'(pmem_address), 128'(16'h2222));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
